// File: rtl/tick_meter_pkg.sv
// Shared definitions for the tick period meter: FSM state encoding and
// default sizing constants used by the top and its sub-module.
package tick_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } meterState_t;

    localparam int DEF_WIDTH   = 27;
    localparam int DEF_TIMEOUT = 100000000;
    localparam int DEF_TOL     = 0;
    localparam int DEF_SYNC    = 2;

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronizes an asynchronous tick input and produces a registered
// one-cycle pulse on each rising edge. All history flops reset to 1 so a
// tick that is already high when reset releases is not seen as an edge.
module tick_sync_edge
    import tick_meter_pkg::*;
#(
    parameter int SYNC = DEF_SYNC
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iTick,
    output logic oEdge
);

    logic [SYNC-1:0] syncChain;
    logic            tickHist;
    logic            edgeReg;

    // Synchronizer chain, previous-value flop and registered rising-edge pulse
    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncChain <= '1;
            tickHist  <= 1'b1;
            edgeReg   <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC-2:0], iTick};
            tickHist  <= syncChain[SYNC-1];
            edgeReg   <= syncChain[SYNC-1] & ~tickHist;
        end
    end

    assign oEdge = edgeReg;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the iClk-cycle spacing between successive rising edges of iTick,
// reports each period with a valid pulse, flags a missing tick after TIMEOUT
// cycles and reports lock when consecutive periods agree within TOL.
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TOL     = DEF_TOL,
    parameter int SYNC    = DEF_SYNC
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iTick,
    input  logic             iEnable,
    output logic [WIDTH-1:0] oPeriod,
    output logic             oValid,
    output logic             oTimeout,
    output logic             oLocked
);

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH:0]   TOL_W     = (WIDTH+1)'(TOL);

    meterState_t      state;
    meterState_t      nextState;
    logic             tickEdge;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] prev;
    logic             doArm;
    logic             doReport;
    logic             doTimeout;
    logic             lockHit;
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]   absDiff;

    tick_sync_edge #(
        .SYNC (SYNC)
    ) uSyncEdge (
        .iClk  (iClk),
        .iRst  (iRst),
        .iTick (iTick),
        .oEdge (tickEdge)
    );

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; dropping iEnable always returns to IDLE, and an edge
    // coinciding with the timeout count keeps measuring instead of re-arming
    always_comb begin
        nextState = state;
        if (!iEnable) begin
            nextState = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: nextState = ST_ARM;
                ST_ARM:  if (tickEdge) nextState = ST_MEAS;
                ST_MEAS: if (!tickEdge && count == TIMEOUT_W) nextState = ST_ARM;
                default: nextState = ST_IDLE;
            endcase
        end
    end

    // Per-cycle action decode and lock comparison against the previous period
    always_comb begin
        doArm     = 1'b0;
        doReport  = 1'b0;
        doTimeout = 1'b0;
        diff      = signed'({1'b0, count}) - signed'({1'b0, prev});
        absDiff   = diff[WIDTH] ? unsigned'(-diff) : unsigned'(diff);
        lockHit   = (absDiff <= TOL_W) && (prev != '0);
        if (iEnable) begin
            doArm     = (state == ST_ARM) && tickEdge;
            doReport  = (state == ST_MEAS) && tickEdge;
            doTimeout = (state == ST_MEAS) && !tickEdge && (count == TIMEOUT_W);
        end
    end

    // Period counter, previous-period memory and registered outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            count    <= '0;
            prev     <= '0;
            oPeriod  <= '0;
            oValid   <= 1'b0;
            oTimeout <= 1'b0;
            oLocked  <= 1'b0;
        end else begin
            oValid   <= 1'b0;
            oTimeout <= 1'b0;
            if (!iEnable) begin
                count   <= '0;
                prev    <= '0;
                oLocked <= 1'b0;
            end else if (doReport) begin
                oPeriod <= count;
                oValid  <= 1'b1;
                oLocked <= lockHit;
                prev    <= count;
                count   <= WIDTH'(1);
            end else if (doTimeout) begin
                oTimeout <= 1'b1;
                oLocked  <= 1'b0;
                prev     <= '0;
                count    <= '0;
            end else if (doArm) begin
                count <= WIDTH'(1);
            end else if (state == ST_MEAS) begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed tick streams with hand-computed
// periods; expected reports and timeouts are queued by the stimulus and
// matched by an independent monitor whenever the DUT pulses an output.
module tb_tick_period_meter;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 50;
    localparam int TOL     = 1;
    localparam int SYNC    = 2;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iTick;
    logic             iEnable;
    logic [WIDTH-1:0] oPeriod;
    logic             oValid;
    logic             oTimeout;
    logic             oLocked;

    typedef struct {
        bit isTimeout;
        int period;
        bit locked;
        int offset;
    } expEvent_t;

    expEvent_t expQ[$];
    expEvent_t monEvent;
    int vecCount     = 0;
    int errCount     = 0;
    int cyc          = 0;
    int lastValidCyc = 0;

    tick_period_meter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT),
        .TOL     (TOL),
        .SYNC    (SYNC)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iTick    (iTick),
        .iEnable  (iEnable),
        .oPeriod  (oPeriod),
        .oValid   (oValid),
        .oTimeout (oTimeout),
        .oLocked  (oLocked)
    );

    // Free-running clock
    always #5 iClk = ~iClk;

    // Cycle counter used to time timeouts relative to the last report
    always @(posedge iClk) cyc = cyc + 1;

    // Hard stop in case the stimulus never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Waits gap cycles after the previous rise, then raises iTick for one cycle.
    task automatic applyStimulus(input int gap, input bit expReport, input int expPeriod,
                                 input bit expLocked);
        expEvent_t e;
        repeat (gap - 1) @(negedge iClk);
        if (expReport) begin
            e.isTimeout = 1'b0;
            e.period    = expPeriod;
            e.locked    = expLocked;
            e.offset    = -1;
            expQ.push_back(e);
        end
        iTick = 1'b1;
        @(negedge iClk);
        iTick = 1'b0;
    endtask

    task automatic expectTimeout(input int offset);
        expEvent_t e;
        e.isTimeout = 1'b1;
        e.period    = 0;
        e.locked    = 1'b0;
        e.offset    = offset;
        expQ.push_back(e);
    endtask

    // Monitor: pops and compares an expectation whenever the DUT pulses an output
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oValid) begin
                if (expQ.size() == 0 || expQ[0].isTimeout) begin
                    checkOutput("unexpected oValid", int'(oValid), 0);
                end else begin
                    monEvent = expQ.pop_front();
                    checkOutput("oPeriod", int'(oPeriod), monEvent.period);
                    checkOutput("oLocked on report", int'(oLocked), int'(monEvent.locked));
                end
                lastValidCyc = cyc;
            end
            if (oTimeout) begin
                if (expQ.size() == 0 || !expQ[0].isTimeout) begin
                    checkOutput("unexpected oTimeout", int'(oTimeout), 0);
                end else begin
                    monEvent = expQ.pop_front();
                    checkOutput("oLocked on timeout", int'(oLocked), 0);
                    if (monEvent.offset >= 0) begin
                        checkOutput("timeout spacing", cyc - lastValidCyc, monEvent.offset);
                    end
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        iRst    = 1'b1;
        iTick   = 1'b0;
        iEnable = 1'b0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        checkOutput("reset oPeriod", int'(oPeriod), 0);
        checkOutput("reset oValid", int'(oValid), 0);
        checkOutput("reset oTimeout", int'(oTimeout), 0);
        checkOutput("reset oLocked", int'(oLocked), 0);
        iEnable = 1'b1;
        repeat (3) @(negedge iClk);

        // Steady 10-cycle ticks: first edge arms, lock from second report on
        applyStimulus(5, 1'b0, 0, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b1);
        applyStimulus(10, 1'b1, 10, 1'b1);

        // Tolerance of 1: 11 stays locked, 13 breaks lock, repeated 13 relocks
        applyStimulus(11, 1'b1, 11, 1'b1);
        applyStimulus(13, 1'b1, 13, 1'b0);
        applyStimulus(13, 1'b1, 13, 1'b1);

        // Silence: timeout 50 cycles after the last report, next edge only re-arms
        expectTimeout(50);
        applyStimulus(75, 1'b0, 0, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b1);

        // Boundary: exactly TIMEOUT apart reports, one more cycle times out
        applyStimulus(50, 1'b1, 50, 1'b0);
        applyStimulus(50, 1'b1, 50, 1'b1);
        expectTimeout(50);
        applyStimulus(51, 1'b0, 0, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b1);

        // Enable dropped mid-period: no report, period held, lock cleared
        repeat (5) @(negedge iClk);
        iEnable = 1'b0;
        repeat (3) @(negedge iClk);
        checkOutput("disable oPeriod held", int'(oPeriod), 10);
        checkOutput("disable oLocked", int'(oLocked), 0);
        iEnable = 1'b1;
        applyStimulus(20, 1'b0, 0, 1'b0);
        applyStimulus(12, 1'b1, 12, 1'b0);
        applyStimulus(12, 1'b1, 12, 1'b1);

        // Reset mid-measurement with iTick held high: no false edge afterwards
        repeat (6) @(negedge iClk);
        iRst  = 1'b1;
        iTick = 1'b1;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        checkOutput("mid reset oPeriod", int'(oPeriod), 0);
        checkOutput("mid reset oValid", int'(oValid), 0);
        checkOutput("mid reset oTimeout", int'(oTimeout), 0);
        checkOutput("mid reset oLocked", int'(oLocked), 0);
        repeat (10) @(negedge iClk);
        iTick = 1'b0;
        applyStimulus(5, 1'b0, 0, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b0);
        applyStimulus(10, 1'b1, 10, 1'b1);

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge iClk);
        repeat (5) @(negedge iClk);
        checkOutput("pending expectations", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
